encoder_8_3_seq: RTL and testbench
==================================

# encoder_8_3_seq

Registered 8-to-3 event encoder, the inverse of the existing 3-to-8 decoder. Captures request pulses on eight lines, holds them as pending events, and emits them one at a time as 3-bit binary codes over a valid/ready handshake. Sits between the decoded one-hot event sources and any consumer that needs a compact event index. Coalesced duplicate requests are counted.

## Interface

Parameters:
- none; widths fixed at 8 request lines, 3-bit code, 8-bit duplicate counter.

Ports:
- clka  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- E  input  1  request enable; when 0, `In` is ignored.
- In  input  8  request lines; bit i high at a rising edge is one request for code i.
- Out  output  3  code of the presented event, registered.
- valid  output  1  `Out` holds an event, registered.
- ready  input  1  consumer accepts `Out` at an edge where `valid && ready`.
- pending  output  8  pending-event register, exposed for debug.
- dup_cnt  output  8  saturating count of coalesced duplicate requests.

## Operation

- `req = In & {8{E}}`.
- Slot free at an edge when `!valid || ready`.
- Load: at an edge with the slot free and `pending != 0`:
  - select code c per the arbitration rule;
  - `Out <= c`, `valid <= 1`, `load_mask = 1<<c`.
  - Otherwise `load_mask = 0`.
- At an edge with the slot free and `pending == 0`: `valid <= 0`, `Out` holds its value.
- Pending update: `pending <= (pending & ~load_mask) | req`.
  - A request for bit c arriving at the same edge that c is loaded re-arms `pending[c]`, giving a second event.
- Duplicate: `req[i] && pending[i] && !load_mask[i]` is a duplicate.
  - `dup_cnt` adds the number of duplicates at that edge (0..8), saturating at 255.
- FSM, two states:
  - IDLE (`valid=0`) -> PRESENT when pending is non-zero.
  - PRESENT (`valid=1`) stays, reloading each accepted edge, while pending is non-zero.
  - PRESENT -> IDLE on acceptance with pending zero.
- `Out`/`valid` are stable while `valid && !ready`. Pending may grow during a stall but is never lost.
- Fixed arbitration: highest set index of `pending` wins.

## Timing

- Reset values: `Out=3'b000`, `valid=0`, `pending=8'h00`, `dup_cnt=8'h00`, round-robin pointer `3'b111`. All apply immediately on `rst` assertion.
- Latency:
  - a request sampled at edge k sets `pending` after edge k;
  - `valid`/`Out` present it after edge k+1, when the slot is free;
  - no combinational path from `In` or `ready` to any output.
- Throughput: one event per clock with `ready` held high.
- Reset mid-operation: all pending events and the presented code are discarded. The first edge after deassertion behaves as from reset.
- `E` low: no new requests. Pending events still drain normally.
- `In=8'hFF` with `pending=8'hFF` and no load: `dup_cnt += 8`, saturating.

## Configuration

- `ENCODER_ROUND_ROBIN_EN`.
  - Defined: the arbitration search starts at `(ptr+1) mod 8`, ascends and wraps. The first set bit wins, and `ptr <= c` on each load. `ptr` resets to `3'b111`, so the first search starts at index 0.
  - Undefined: fixed highest-index priority; no pointer register.

## Test plan

- Reset then `E=1`, `In=8'b0000_0100` for one cycle, `ready=1` -> `valid=1`, `Out=3'd2` two edges after the request edge, for exactly one cycle. `pending=0` afterwards.
- `In=8'b1000_0001` in one cycle, `ready=1`, fixed mode -> `Out` sequence 7 then 0 on consecutive cycles. With `ENCODER_ROUND_ROBIN_EN`: 0 then 7.
- `ready=0` while `valid=1` with `Out=5`, new requests on bits 1 and 3 -> `Out` stays 5. After `ready=1`, emits 3 then 1 (fixed mode); no events lost.
- `In[4]` asserted on three consecutive edges with `ready=0` and `pending[4]` already set -> `dup_cnt` increments by 1 per edge to 3. Only one code 4 is emitted.
- `E=0` with `In=8'hFF` -> `pending` unchanged, `dup_cnt` unchanged, no new `valid`.
- `rst` pulsed while `valid=1` and `pending=8'h3C` -> `valid=0`, `Out=0`, `pending=0`, `dup_cnt=0` immediately. No events are emitted after deassertion without new requests.

Source files
------------

// File: rtl/encoder_8_3_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8_3_seq_if
// Description : Request/event bundle for the registered 8-to-3 event encoder.
//               The request side drives E, In and ready. The encoder drives
//               Out, valid, pending and dup_cnt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   E        request enable; when low, In is ignored
//   In[7:0]  one-hot-ish request lines, bit i = request for code i
//   Out[2:0] code of the presented event
//   valid    Out holds an event
//   ready    consumer accepts Out at an edge where valid && ready
//   pending  pending-event register (debug view)
//   dup_cnt  saturating count of coalesced duplicate requests
// Modports:
//   master   request source / consumer side
//   slave    encoder side
// ============================================================================
interface encoder_8_3_seq_if;
    logic       E;
    logic [7:0] In;
    logic [2:0] Out;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic [7:0] dup_cnt;

    modport master (
        output E,
        output In,
        output ready,
        input  Out,
        input  valid,
        input  pending,
        input  dup_cnt
    );

    modport slave (
        input  E,
        input  In,
        input  ready,
        output Out,
        output valid,
        output pending,
        output dup_cnt
    );
endinterface
`default_nettype wire

// File: rtl/encoder_8_3_seq.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8_3_seq
// Description : Registered 8-to-3 event encoder. Request pulses on eight lines
//               are captured into a pending-event register and emitted one at
//               a time as 3-bit codes over a valid/ready handshake. Requests
//               that hit an already-pending, not-being-loaded bit are
//               coalesced and counted in a saturating duplicate counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clka  input   clock, all state updates on its rising edge
//   rst   input   asynchronous active-high reset
//   bus   slave   encoder_8_3_seq_if (E, In, ready in; Out, valid, pending,
//                 dup_cnt out)
// Configuration:
//   ENCODER_ROUND_ROBIN_EN  defined   : round-robin arbitration, search starts
//                                       one past the last loaded code
//                           undefined : fixed priority, highest index wins
// ============================================================================
module encoder_8_3_seq (
    input  logic               clka,
    input  logic               rst,
    encoder_8_3_seq_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_out;
    logic [7:0] r_pending;
    logic [7:0] r_dup_cnt;

    logic [7:0] w_req;
    logic       w_slot_free;
    logic       w_load;
    logic [2:0] w_code;
    logic [7:0] w_load_mask;
    logic [7:0] w_pending_next;
    logic [7:0] w_dup_vec;
    logic [3:0] w_dup_num;
    logic [8:0] w_dup_sum;
    logic [7:0] w_dup_next;

    assign w_req       = bus.In & {8{bus.E}};
    assign w_slot_free = (r_state == ST_IDLE) || bus.ready;
    assign w_load      = w_slot_free && (r_pending != 8'h00);
    assign w_load_mask = w_load ? (8'h01 << w_code) : 8'h00;

    // A request landing on the bit being loaded re-arms it: the loaded event
    // and the new request are two distinct events, not a duplicate.
    assign w_pending_next = (r_pending & ~w_load_mask) | w_req;
    assign w_dup_vec      = w_req & r_pending & ~w_load_mask;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [2:0] r_ptr;
    logic [2:0] w_idx;
    logic       w_found;

    // Search ascends from ptr+1 and wraps; 3-bit arithmetic does the mod 8.
    always_comb begin
        w_code  = 3'd0;
        w_idx   = 3'd0;
        w_found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w_idx = r_ptr + 3'd1 + 3'(k);
            if (!w_found && r_pending[w_idx]) begin
                w_code  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_ptr <= 3'b111;
        end else if (w_load) begin
            r_ptr <= w_code;
        end
    end
`else
    // Ascending scan, last set bit wins: highest index has priority.
    always_comb begin
        w_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_pending[i]) begin
                w_code = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        w_dup_num = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_dup_num = w_dup_num + {3'b000, w_dup_vec[i]};
        end
    end

    assign w_dup_sum  = {1'b0, r_dup_cnt} + {5'b00000, w_dup_num};
    assign w_dup_next = w_dup_sum[8] ? 8'hFF : w_dup_sum[7:0];

    // Handshake FSM with registered outputs. Out only changes on a load, so
    // Out/valid are stable while valid && !ready.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_out     <= 3'b000;
            r_pending <= 8'h00;
            r_dup_cnt <= 8'h00;
        end else begin
            r_pending <= w_pending_next;
            r_dup_cnt <= w_dup_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_out   <= w_code;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.ready) begin
                        if (w_load) begin
                            r_out <= w_code;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Out     = r_out;
    assign bus.valid   = (r_state == ST_PRESENT);
    assign bus.pending = r_pending;
    assign bus.dup_cnt = r_dup_cnt;

endmodule
`default_nettype wire

// File: tb/tb_encoder_8_3_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_8_3_seq
// Description : Self-checking bench for encoder_8_3_seq. Expected codes are
//               queued when requests are driven and compared when the encoder
//               hands an event over (valid && ready).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_8_3_seq;

    logic clka;
    logic rst;

    encoder_8_3_seq_if bus ();

    encoder_8_3_seq u_dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    int         checks;
    int         errors;
    logic [2:0] sb[$];

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Scoreboard consumer: a handshake seen at the falling edge completes at
    // the following rising edge.
    always @(negedge clka) begin
        logic [2:0] exp_code;
        if (!rst && bus.valid === 1'b1 && bus.ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: Out=%0d emitted, no event expected", bus.Out);
            end else begin
                exp_code = sb.pop_front();
                if (bus.Out !== exp_code) begin
                    errors++;
                    $display("FAIL event_code: Out=%0d expected %0d", bus.Out, exp_code);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.E     = 1'b0;
        bus.In    = 8'h00;
        bus.ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d events still outstanding, expected 0", sb.size());
            sb.delete();
        end
        tick();
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: valid=%b expected 0", bus.valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.E     = 1'b0;
        bus.In    = 8'h00;
        bus.ready = 1'b0;
        tick();
        checks += 4;
        if (bus.Out !== 3'd0) begin errors++; $display("FAIL reset_out: Out=%0d expected 0", bus.Out); end
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: valid=%b expected 0", bus.valid); end
        if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending: pending=%h expected 00", bus.pending); end
        if (bus.dup_cnt !== 8'h00) begin errors++; $display("FAIL reset_dup: dup_cnt=%h expected 00", bus.dup_cnt); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.E = 1'b1; bus.In = 8'b0000_0100; bus.ready = 1'b1;
        sb.push_back(3'd2);
        tick();
        bus.In = 8'h00;
        checks += 2;
        if (bus.pending !== 8'h04) begin errors++; $display("FAIL single_pending: pending=%h expected 04", bus.pending); end
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_early: valid=%b expected 0", bus.valid); end
        tick();
        checks += 3;
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid: valid=%b expected 1", bus.valid); end
        if (bus.Out !== 3'd2) begin errors++; $display("FAIL single_out: Out=%0d expected 2", bus.Out); end
        if (bus.pending !== 8'h00) begin errors++; $display("FAIL single_clear: pending=%h expected 00", bus.pending); end
        tick();
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_once: valid=%b expected 0", bus.valid); end
        wait_drain(10);
    endtask

    task automatic test_two_codes();
        do_reset();
        bus.E = 1'b1; bus.In = 8'b1000_0001; bus.ready = 1'b1;
`ifdef ENCODER_ROUND_ROBIN_EN
        sb.push_back(3'd0); sb.push_back(3'd7);
`else
        sb.push_back(3'd7); sb.push_back(3'd0);
`endif
        tick();
        bus.In = 8'h00;
        tick();
        tick();
        // Second code must follow on the very next cycle.
        checks++;
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL two_back_to_back: valid=%b expected 1", bus.valid); end
        wait_drain(10);
    endtask

    task automatic test_stall();
        do_reset();
        bus.E = 1'b1; bus.In = 8'b0010_0000; bus.ready = 1'b0;
        sb.push_back(3'd5);
        tick();
        bus.In = 8'h00;
        tick();
        checks += 2;
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL stall_valid: valid=%b expected 1", bus.valid); end
        if (bus.Out !== 3'd5) begin errors++; $display("FAIL stall_first: Out=%0d expected 5", bus.Out); end
        bus.In = 8'b0000_1010;
`ifdef ENCODER_ROUND_ROBIN_EN
        sb.push_back(3'd1); sb.push_back(3'd3);
`else
        sb.push_back(3'd3); sb.push_back(3'd1);
`endif
        tick();
        bus.In = 8'h00;
        tick();
        tick();
        checks += 3;
        if (bus.Out !== 3'd5) begin errors++; $display("FAIL stall_hold: Out=%0d expected 5", bus.Out); end
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid: valid=%b expected 1", bus.valid); end
        if (bus.pending !== 8'h0A) begin errors++; $display("FAIL stall_pending: pending=%h expected 0a", bus.pending); end
        bus.ready = 1'b1;
        wait_drain(10);
    endtask

    task automatic test_duplicates();
        do_reset();
        bus.E = 1'b1; bus.In = 8'h80; bus.ready = 1'b0;
        sb.push_back(3'd7);
        tick();
        bus.In = 8'h10;
        sb.push_back(3'd4);
        tick();
        checks++;
        if (bus.dup_cnt !== 8'd0) begin errors++; $display("FAIL dup_first: dup_cnt=%0d expected 0", bus.dup_cnt); end
        for (int n = 1; n <= 3; n++) begin
            tick();
            checks++;
            if (bus.dup_cnt !== 8'(n)) begin
                errors++;
                $display("FAIL dup_step: dup_cnt=%0d expected %0d", bus.dup_cnt, n);
            end
        end
        bus.In = 8'h00;
        tick();
        checks += 2;
        if (bus.pending !== 8'h10) begin errors++; $display("FAIL dup_pending: pending=%h expected 10", bus.pending); end
        if (bus.dup_cnt !== 8'd3) begin errors++; $display("FAIL dup_final: dup_cnt=%0d expected 3", bus.dup_cnt); end
        bus.ready = 1'b1;
        wait_drain(10);
    endtask

    task automatic test_enable_low();
        logic [2:0] exp_first;
        logic [2:0] exp_second;
        logic [7:0] exp_pend;
`ifdef ENCODER_ROUND_ROBIN_EN
        exp_first = 3'd0; exp_second = 3'd1; exp_pend = 8'h02;
`else
        exp_first = 3'd1; exp_second = 3'd0; exp_pend = 8'h01;
`endif
        do_reset();
        bus.E = 1'b1; bus.In = 8'h03; bus.ready = 1'b0;
        tick();
        bus.In = 8'h00;
        tick();
        bus.E = 1'b0; bus.In = 8'hFF;
        repeat (3) tick();
        checks += 4;
        if (bus.pending !== exp_pend) begin errors++; $display("FAIL en_pending: pending=%h expected %h", bus.pending, exp_pend); end
        if (bus.dup_cnt !== 8'd0) begin errors++; $display("FAIL en_dup: dup_cnt=%0d expected 0", bus.dup_cnt); end
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL en_valid: valid=%b expected 1", bus.valid); end
        if (bus.Out !== exp_first) begin errors++; $display("FAIL en_out: Out=%0d expected %0d", bus.Out, exp_first); end
        sb.push_back(exp_first); sb.push_back(exp_second);
        bus.ready = 1'b1;
        wait_drain(10);
        repeat (3) tick();
        checks += 2;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL en_no_new: valid=%b expected 0", bus.valid); end
        if (bus.pending !== 8'h00) begin errors++; $display("FAIL en_empty: pending=%h expected 00", bus.pending); end
        bus.In = 8'h00;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.E = 1'b1; bus.In = 8'hFF; bus.ready = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.dup_cnt !== 8'd7) begin errors++; $display("FAIL sat_load_edge: dup_cnt=%0d expected 7", bus.dup_cnt); end
        tick();
        checks++;
        if (bus.dup_cnt !== 8'd15) begin errors++; $display("FAIL sat_plus8: dup_cnt=%0d expected 15", bus.dup_cnt); end
        repeat (35) tick();
        bus.In = 8'h00;
        tick();
        checks++;
        if (bus.dup_cnt !== 8'd255) begin errors++; $display("FAIL sat_cap: dup_cnt=%0d expected 255", bus.dup_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.E = 1'b1; bus.In = 8'h80; bus.ready = 1'b0;
        tick();
        bus.In = 8'h3C;
        tick();
        bus.In = 8'h00;
        checks += 2;
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL mid_valid: valid=%b expected 1", bus.valid); end
        if (bus.pending !== 8'h3C) begin errors++; $display("FAIL mid_pending: pending=%h expected 3c", bus.pending); end
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: valid=%b expected 0", bus.valid); end
        if (bus.Out !== 3'd0) begin errors++; $display("FAIL mid_rst_out: Out=%0d expected 0", bus.Out); end
        if (bus.pending !== 8'h00) begin errors++; $display("FAIL mid_rst_pending: pending=%h expected 00", bus.pending); end
        if (bus.dup_cnt !== 8'h00) begin errors++; $display("FAIL mid_rst_dup: dup_cnt=%0d expected 0", bus.dup_cnt); end
        tick();
        tick();
        rst = 1'b0;
        bus.ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_after: valid=%b expected 0", bus.valid); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.E     = 1'b0;
        bus.In    = 8'h00;
        bus.ready = 1'b0;
        test_reset();
        test_single();
        test_two_codes();
        test_stall();
        test_duplicates();
        test_enable_low();
        test_saturation();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: %0d queued, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
